// File: rtl/mano_pkg.sv
// Shared encodings and default widths for the Mano basic-computer datapath.
// The bus-source and ALU-operation codes match the control-unit encoding.
package mano_pkg;

   localparam int DW_DEF  = 16;
   localparam int AW_DEF  = 12;
   localparam int IOW_DEF = 8;

   typedef enum logic [2:0] {
      BUS_ZERO = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   typedef enum logic [2:0] {
      ALU_AND  = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_LDDR = 3'd2,
      ALU_INPR = 3'd3,
      ALU_CMA  = 3'd4,
      ALU_CIR  = 3'd5,
      ALU_CIL  = 3'd6,
      ALU_PASS = 3'd7
   } alu_op_e;

endpackage

// File: rtl/mano_datapath_w_if.sv
// Memory bus and FGI/FGO device handshake of the datapath.
// The master side is the datapath; the slave side is memory plus the I/O device.
interface mano_datapath_w_if #(
   parameter int DW  = 16,
   parameter int AW  = 12,
   parameter int IOW = 8
);
   logic [DW-1:0]  mem_rdata;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  bus;
   logic           in_valid;
   logic [IOW-1:0] in_data;
   logic           in_ready;
   logic           out_ack;
   logic           out_valid;
   logic [IOW-1:0] outr;

   modport master (
      input  mem_rdata, in_valid, in_data, out_ack,
      output mem_addr, bus, in_ready, out_valid, outr
   );

   modport slave (
      output mem_rdata, in_valid, in_data, out_ack,
      input  mem_addr, bus, in_ready, out_valid, outr
   );
endinterface

// File: rtl/mano_alu_w.sv
// Combinational ALU feeding AC and the E carry: logic, add, rotate-through-E
// and the INPR merge into the low I/O byte of AC.
module mano_alu_w
   import mano_pkg::*;
#(
   parameter int DW  = 16,
   parameter int IOW = 8
) (
   input  logic [DW-1:0]  ac,
   input  logic [DW-1:0]  dr,
   input  logic           e,
   input  logic [IOW-1:0] inpr,
   input  alu_op_e        op,
   output logic [DW-1:0]  res,
   output logic           carry
);

   always_comb begin
      res   = ac;
      carry = e;
      case (op)
         ALU_AND:  res = ac & dr;
         ALU_ADD:  {carry, res} = {1'b0, ac} + {1'b0, dr};
         ALU_LDDR: res = dr;
         ALU_INPR: res[IOW-1:0] = inpr;
         ALU_CMA:  res = ~ac;
         ALU_CIR: begin
            res   = {e, ac[DW-1:1]};
            carry = ac[0];
         end
         ALU_CIL: begin
            res   = {ac[DW-2:0], e};
            carry = ac[DW-1];
         end
         ALU_PASS: res = ac;
      endcase
   end

endmodule

// File: rtl/mano_datapath_w.sv
// Mano basic-computer datapath: register file, common bus, E flip-flop and
// FGI/FGO I/O flags, driven by per-register strobes from the control unit.
module mano_datapath_w
   import mano_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int AW  = AW_DEF,
   parameter int IOW = IOW_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  bus_sel_e            bus_sel,
   input  alu_op_e             alu_op,
   input  logic                ar_ld, ar_inc, ar_clr,
   input  logic                pc_ld, pc_inc, pc_clr,
   input  logic                dr_ld, dr_inc, dr_clr,
   input  logic                ac_ld, ac_inc, ac_clr,
   input  logic                tr_ld, tr_inc, tr_clr,
   input  logic                ir_ld, outr_ld,
   input  logic                e_clr, e_cmp, e_ld,
   input  logic                fgi_clr,
   mano_datapath_w_if.master   io,
   output logic [AW-1:0]       ar,
   output logic [AW-1:0]       pc,
   output logic [DW-1:0]       dr,
   output logic [DW-1:0]       ac,
   output logic [DW-1:0]       ir,
   output logic [DW-1:0]       tr,
   output logic                e,
   output logic                fgi,
   output logic                fgo,
   output logic                ac_zero,
   output logic                ac_neg,
   output logic                dr_zero
);

   logic [AW-1:0]  ar_q, ar_d, pc_q, pc_d;
   logic [DW-1:0]  dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
   logic [IOW-1:0] outr_q, outr_d, inpr_q, inpr_d;
   logic           e_q, e_d, fgi_q, fgi_d, fgo_q, fgo_d;
   logic [DW-1:0]  bus_w, alu_res;
   logic           alu_carry;

   always_comb begin
      bus_w = '0;
      case (bus_sel)
         BUS_ZERO: bus_w = '0;
         BUS_AR:   bus_w = DW'(ar_q);
         BUS_PC:   bus_w = DW'(pc_q);
         BUS_DR:   bus_w = dr_q;
         BUS_AC:   bus_w = ac_q;
         BUS_IR:   bus_w = ir_q;
         BUS_TR:   bus_w = tr_q;
         BUS_MEM:  bus_w = io.mem_rdata;
      endcase
   end

   mano_alu_w #(.DW(DW), .IOW(IOW)) u_alu (
      .ac    (ac_q),
      .dr    (dr_q),
      .e     (e_q),
      .inpr  (inpr_q),
      .op    (alu_op),
      .res   (alu_res),
      .carry (alu_carry)
   );

   // Every register resolves clear over load over increment.
   always_comb begin
      ar_d = ar_clr ? '0 : ar_ld ? bus_w[AW-1:0] : ar_inc ? ar_q + AW'(1) : ar_q;
      pc_d = pc_clr ? '0 : pc_ld ? bus_w[AW-1:0] : pc_inc ? pc_q + AW'(1) : pc_q;
      dr_d = dr_clr ? '0 : dr_ld ? bus_w : dr_inc ? dr_q + DW'(1) : dr_q;
      ac_d = ac_clr ? '0 : ac_ld ? alu_res : ac_inc ? ac_q + DW'(1) : ac_q;
      tr_d = tr_clr ? '0 : tr_ld ? bus_w : tr_inc ? tr_q + DW'(1) : tr_q;
      ir_d = ir_ld ? bus_w : ir_q;
      outr_d = outr_ld ? bus_w[IOW-1:0] : outr_q;
      e_d = e_clr ? 1'b0 : e_cmp ? ~e_q : e_ld ? alu_carry : e_q;
   end

   // An offer arriving with fgi_clr while FGI is set waits one cycle.
   always_comb begin
      fgi_d  = fgi_q;
      inpr_d = inpr_q;
      if (io.in_valid && !fgi_q) begin
         inpr_d = io.in_data;
         fgi_d  = 1'b1;
      end else if (fgi_clr) begin
         fgi_d  = 1'b0;
      end
      fgo_d = fgo_q;
      if (outr_ld) fgo_d = 1'b0;
      else if (io.out_ack) fgo_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ar_q   <= '0;
         pc_q   <= '0;
         dr_q   <= '0;
         ac_q   <= '0;
         ir_q   <= '0;
         tr_q   <= '0;
         outr_q <= '0;
         inpr_q <= '0;
         e_q    <= 1'b0;
         fgi_q  <= 1'b0;
         fgo_q  <= 1'b1;
      end else begin
         ar_q   <= ar_d;
         pc_q   <= pc_d;
         dr_q   <= dr_d;
         ac_q   <= ac_d;
         ir_q   <= ir_d;
         tr_q   <= tr_d;
         outr_q <= outr_d;
         inpr_q <= inpr_d;
         e_q    <= e_d;
         fgi_q  <= fgi_d;
         fgo_q  <= fgo_d;
      end
   end

   assign io.mem_addr  = ar_q;
   assign io.bus       = bus_w;
   assign io.in_ready  = ~fgi_q;
   assign io.out_valid = ~fgo_q;
   assign io.outr      = outr_q;

   assign ar      = ar_q;
   assign pc      = pc_q;
   assign dr      = dr_q;
   assign ac      = ac_q;
   assign ir      = ir_q;
   assign tr      = tr_q;
   assign e       = e_q;
   assign fgi     = fgi_q;
   assign fgo     = fgo_q;
   assign ac_zero = (ac_q == '0);
   assign ac_neg  = ac_q[DW-1];
   assign dr_zero = (dr_q == '0);

endmodule

// File: tb/tb_mano_datapath_w.sv
// Directed bench for mano_datapath_w: a vector table plus hand sequences on a
// 16/12/8 instance, then a short rerun on a 24/16/8 instance sharing the strobes.
module tb_mano_datapath_w;
   import mano_pkg::*;

   localparam logic [22:0] AR_LD   = 23'd1 << 22;
   localparam logic [22:0] PC_LD   = 23'd1 << 19;
   localparam logic [22:0] PC_INC  = 23'd1 << 18;
   localparam logic [22:0] PC_CLR  = 23'd1 << 17;
   localparam logic [22:0] DR_LD   = 23'd1 << 16;
   localparam logic [22:0] DR_INC  = 23'd1 << 15;
   localparam logic [22:0] DR_CLR  = 23'd1 << 14;
   localparam logic [22:0] AC_LD   = 23'd1 << 13;
   localparam logic [22:0] AC_INC  = 23'd1 << 12;
   localparam logic [22:0] AC_CLR  = 23'd1 << 11;
   localparam logic [22:0] TR_LD   = 23'd1 << 10;
   localparam logic [22:0] TR_INC  = 23'd1 << 9;
   localparam logic [22:0] IR_LD   = 23'd1 << 7;
   localparam logic [22:0] OUTR_LD = 23'd1 << 6;
   localparam logic [22:0] E_CLR   = 23'd1 << 5;
   localparam logic [22:0] E_CMP   = 23'd1 << 4;
   localparam logic [22:0] E_LD    = 23'd1 << 3;
   localparam logic [22:0] FGI_CLR = 23'd1 << 2;
   localparam logic [22:0] OUT_ACK = 23'd1 << 1;
   localparam logic [22:0] IN_VLD  = 23'd1 << 0;
   localparam logic [22:0] NONE    = 23'd0;

   typedef struct {
      logic [22:0] st;
      bus_sel_e    bs;
      alu_op_e     op;
      logic [15:0] mrd;
      logic [15:0] ac;
      logic [11:0] pc;
      logic        e;
      logic        fgi;
      logic        fgo;
      logic        az;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [22:0] st = '0;
   bus_sel_e    bsel = BUS_ZERO;
   alu_op_e     aop = ALU_PASS;
   logic [23:0] mrd = '0;
   logic [7:0]  din = '0;
   logic ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, dr_clr;
   logic ac_ld, ac_inc, ac_clr, tr_ld, tr_inc, tr_clr, ir_ld, outr_ld;
   logic e_clr, e_cmp, e_ld, fgi_clr, out_ack, in_valid;

   int n_cmp = 0;
   int n_fail = 0;
   vec_t tbl[28];

   always #5 clk = ~clk;

   assign {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, dr_clr,
           ac_ld, ac_inc, ac_clr, tr_ld, tr_inc, tr_clr, ir_ld, outr_ld,
           e_clr, e_cmp, e_ld, fgi_clr, out_ack, in_valid} = st;

   mano_datapath_w_if #(.DW(16), .AW(12), .IOW(8)) ifa ();
   mano_datapath_w_if #(.DW(24), .AW(16), .IOW(8)) ifb ();

   assign ifa.mem_rdata = mrd[15:0];
   assign ifb.mem_rdata = mrd;
   assign ifa.in_valid  = in_valid;
   assign ifb.in_valid  = in_valid;
   assign ifa.in_data   = din;
   assign ifb.in_data   = din;
   assign ifa.out_ack   = out_ack;
   assign ifb.out_ack   = out_ack;

   logic [11:0] a_ar, a_pc;
   logic [15:0] a_dr, a_ac, a_ir, a_tr;
   logic        a_e, a_fgi, a_fgo, a_acz, a_acn, a_drz;
   logic [15:0] b_ar, b_pc;
   logic [23:0] b_dr, b_ac, b_ir, b_tr;
   logic        b_e, b_fgi, b_fgo, b_acz, b_acn, b_drz;

   mano_datapath_w #(.DW(16), .AW(12), .IOW(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus_sel(bsel), .alu_op(aop),
      .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
      .dr_ld(dr_ld), .dr_inc(dr_inc), .dr_clr(dr_clr),
      .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr),
      .tr_ld(tr_ld), .tr_inc(tr_inc), .tr_clr(tr_clr),
      .ir_ld(ir_ld), .outr_ld(outr_ld),
      .e_clr(e_clr), .e_cmp(e_cmp), .e_ld(e_ld), .fgi_clr(fgi_clr),
      .io(ifa),
      .ar(a_ar), .pc(a_pc), .dr(a_dr), .ac(a_ac), .ir(a_ir), .tr(a_tr),
      .e(a_e), .fgi(a_fgi), .fgo(a_fgo),
      .ac_zero(a_acz), .ac_neg(a_acn), .dr_zero(a_drz)
   );

   mano_datapath_w #(.DW(24), .AW(16), .IOW(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus_sel(bsel), .alu_op(aop),
      .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
      .dr_ld(dr_ld), .dr_inc(dr_inc), .dr_clr(dr_clr),
      .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr),
      .tr_ld(tr_ld), .tr_inc(tr_inc), .tr_clr(tr_clr),
      .ir_ld(ir_ld), .outr_ld(outr_ld),
      .e_clr(e_clr), .e_cmp(e_cmp), .e_ld(e_ld), .fgi_clr(fgi_clr),
      .io(ifb),
      .ar(b_ar), .pc(b_pc), .dr(b_dr), .ac(b_ac), .ir(b_ir), .tr(b_tr),
      .e(b_e), .fgi(b_fgi), .fgo(b_fgo),
      .ac_zero(b_acz), .ac_neg(b_acn), .dr_zero(b_drz)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [22:0] s, input bus_sel_e b, input alu_op_e o,
                       input logic [23:0] m, input logic [7:0] d);
      st = s; bsel = b; aop = o; mrd = m; din = d;
      @(posedge clk);
      #1;
      st = '0; bsel = BUS_ZERO; aop = ALU_PASS; mrd = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{DR_LD,               BUS_MEM,  ALU_PASS, 16'hFFFF, 16'h0000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{AC_LD,               BUS_ZERO, ALU_LDDR, 16'h0000, 16'hFFFF, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{DR_LD,               BUS_MEM,  ALU_PASS, 16'h0001, 16'hFFFF, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{AC_LD | E_LD,        BUS_ZERO, ALU_ADD,  16'h0000, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{PC_LD,               BUS_MEM,  ALU_PASS, 16'h0FFF, 16'h0000, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{PC_INC,              BUS_ZERO, ALU_PASS, 16'h0000, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{PC_LD | PC_CLR,      BUS_MEM,  ALU_PASS, 16'h0123, 16'h0000, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{PC_LD | PC_INC,      BUS_MEM,  ALU_PASS, 16'h0ABC, 16'h0000, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{E_CMP,               BUS_ZERO, ALU_PASS, 16'h0000, 16'h0000, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{E_CMP | E_LD,        BUS_ZERO, ALU_ADD,  16'h0000, 16'h0000, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{E_CLR | E_LD,        BUS_ZERO, ALU_PASS, 16'h0000, 16'h0000, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{DR_LD,               BUS_MEM,  ALU_PASS, 16'h8001, 16'h0000, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{AC_LD,               BUS_ZERO, ALU_LDDR, 16'h0000, 16'h8001, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{AC_LD | E_LD,        BUS_ZERO, ALU_CIL,  16'h0000, 16'h0002, 12'hABC, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{AC_LD | E_LD,        BUS_ZERO, ALU_CIR,  16'h0000, 16'h8001, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{AC_LD,               BUS_ZERO, ALU_CMA,  16'h0000, 16'h7FFE, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{AC_INC,              BUS_ZERO, ALU_PASS, 16'h0000, 16'h7FFF, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{AC_CLR|AC_LD|AC_INC, BUS_ZERO, ALU_PASS, 16'h0000, 16'h0000, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[18] = '{DR_LD,               BUS_MEM,  ALU_PASS, 16'h0F0F, 16'h0000, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[19] = '{AC_LD,               BUS_ZERO, ALU_LDDR, 16'h0000, 16'h0F0F, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[20] = '{DR_LD,               BUS_MEM,  ALU_PASS, 16'h00FF, 16'h0F0F, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{AC_LD,               BUS_ZERO, ALU_AND,  16'h0000, 16'h000F, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[22] = '{AC_LD | DR_LD,       BUS_MEM,  ALU_ADD,  16'h0100, 16'h010E, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[23] = '{AC_LD | E_LD,        BUS_ZERO, ALU_ADD,  16'h0000, 16'h020E, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[24] = '{OUTR_LD,             BUS_AC,   ALU_PASS, 16'h0000, 16'h020E, 12'hABC, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[25] = '{OUTR_LD | OUT_ACK,   BUS_AC,   ALU_PASS, 16'h0000, 16'h020E, 12'hABC, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[26] = '{OUT_ACK,             BUS_ZERO, ALU_PASS, 16'h0000, 16'h020E, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[27] = '{OUT_ACK,             BUS_ZERO, ALU_PASS, 16'h0000, 16'h020E, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_ar", a_ar, 0);   chk("rst_a_pc", a_pc, 0);   chk("rst_a_dr", a_dr, 0);
      chk("rst_a_ac", a_ac, 0);   chk("rst_a_ir", a_ir, 0);   chk("rst_a_tr", a_tr, 0);
      chk("rst_a_e", a_e, 0);     chk("rst_a_fgi", a_fgi, 0); chk("rst_a_fgo", a_fgo, 1);
      chk("rst_a_in_ready", ifa.in_ready, 1);  chk("rst_a_out_valid", ifa.out_valid, 0);
      chk("rst_a_outr", ifa.outr, 0);          chk("rst_a_dr_zero", a_drz, 1);
      chk("rst_b_ar", b_ar, 0);   chk("rst_b_pc", b_pc, 0);   chk("rst_b_dr", b_dr, 0);
      chk("rst_b_ir", b_ir, 0);   chk("rst_b_tr", b_tr, 0);   chk("rst_b_fgo", b_fgo, 1);
      chk("rst_b_fgi", b_fgi, 0); chk("rst_b_dr_zero", b_drz, 1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_a_fgo", a_fgo, 1);
      chk("post_rst_a_ac", a_ac, 0);

      for (int i = 0; i < 28; i++) begin
         step(tbl[i].st, tbl[i].bs, tbl[i].op, {8'h00, tbl[i].mrd}, 8'h00);
         chk($sformatf("v%0d_ac", i), a_ac, tbl[i].ac);
         chk($sformatf("v%0d_pc", i), a_pc, tbl[i].pc);
         chk($sformatf("v%0d_e", i), a_e, tbl[i].e);
         chk($sformatf("v%0d_fgi", i), a_fgi, tbl[i].fgi);
         chk($sformatf("v%0d_fgo", i), a_fgo, tbl[i].fgo);
         chk($sformatf("v%0d_ac_zero", i), a_acz, tbl[i].az);
      end
      chk("outr_after_table", ifa.outr, 8'h0E);

      bsel = BUS_PC; #1;
      chk("bus_pc_zext", ifa.bus, 16'h0ABC);
      step(AR_LD, BUS_MEM, ALU_PASS, 24'h001234, 8'h00);
      chk("ar_low_bits", a_ar, 12'h234);
      chk("mem_addr", ifa.mem_addr, 12'h234);
      bsel = BUS_AR; #1;
      chk("bus_ar_zext", ifa.bus, 16'h0234);
      step(TR_LD, BUS_MEM, ALU_PASS, 24'h00BEEF, 8'h00);
      chk("tr_ld", a_tr, 16'hBEEF);
      step(TR_INC, BUS_ZERO, ALU_PASS, 24'h0, 8'h00);
      chk("tr_inc", a_tr, 16'hBEF0);
      step(IR_LD, BUS_TR, ALU_PASS, 24'h0, 8'h00);
      chk("ir_from_tr", a_ir, 16'hBEF0);
      chk("dr_zero_nz", a_drz, 0);
      step(DR_LD | DR_CLR, BUS_MEM, ALU_PASS, 24'h00FFFF, 8'h00);
      chk("dr_clr_over_ld", a_dr, 0);
      chk("dr_zero", a_drz, 1);
      step(DR_INC, BUS_ZERO, ALU_PASS, 24'h0, 8'h00);
      chk("dr_inc", a_dr, 1);

      step(DR_LD, BUS_MEM, ALU_PASS, 24'h000041, 8'h00);
      step(AC_LD, BUS_ZERO, ALU_LDDR, 24'h0, 8'h00);
      chk("ac_0041", a_ac, 16'h0041);
      step(OUTR_LD, BUS_AC, ALU_PASS, 24'h0, 8'h00);
      chk("outr_41", ifa.outr, 8'h41);
      chk("out_valid_set", ifa.out_valid, 1);
      step(OUTR_LD | OUT_ACK, BUS_AC, ALU_PASS, 24'h0, 8'h00);
      chk("outr_ld_beats_ack", ifa.out_valid, 1);
      step(OUT_ACK, BUS_ZERO, ALU_PASS, 24'h0, 8'h00);
      chk("out_ack_done", ifa.out_valid, 0);

      step(IN_VLD, BUS_ZERO, ALU_PASS, 24'h0, 8'h5A);
      chk("fgi_set", a_fgi, 1);
      chk("in_ready_low", ifa.in_ready, 0);
      step(IN_VLD, BUS_ZERO, ALU_PASS, 24'h0, 8'hA5);
      chk("fgi_held", a_fgi, 1);
      step(DR_LD, BUS_MEM, ALU_PASS, 24'h001200, 8'h00);
      step(AC_LD, BUS_ZERO, ALU_LDDR, 24'h0, 8'h00);
      step(AC_LD, BUS_ZERO, ALU_INPR, 24'h0, 8'h00);
      chk("ac_inpr_merge", a_ac, 16'h125A);
      step(FGI_CLR | IN_VLD, BUS_ZERO, ALU_PASS, 24'h0, 8'h33);
      chk("fgi_clr_wins", a_fgi, 0);
      chk("in_ready_back", ifa.in_ready, 1);
      step(IN_VLD, BUS_ZERO, ALU_PASS, 24'h0, 8'h33);
      chk("fgi_reaccept", a_fgi, 1);
      step(AC_LD, BUS_ZERO, ALU_INPR, 24'h0, 8'h00);
      chk("ac_inpr_33", a_ac, 16'h1233);
      step(AC_LD, BUS_ZERO, ALU_CMA, 24'h0, 8'h00);
      chk("ac_neg", a_acn, 1);

      step(OUTR_LD, BUS_AC, ALU_PASS, 24'h0, 8'h00);
      chk("pre_reset_out_valid", ifa.out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_fgo", a_fgo, 1);
      chk("async_rst_out_valid", ifa.out_valid, 0);
      chk("async_rst_in_ready", ifa.in_ready, 1);
      chk("async_rst_ac", a_ac, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      step(DR_LD, BUS_MEM, ALU_PASS, 24'hFFFFFF, 8'h00);
      chk("b_dr_ld", b_dr, 24'hFFFFFF);
      step(AC_LD, BUS_ZERO, ALU_LDDR, 24'h0, 8'h00);
      chk("b_ac_ffffff", b_ac, 24'hFFFFFF);
      step(DR_LD, BUS_MEM, ALU_PASS, 24'h000001, 8'h00);
      step(AC_LD | E_LD, BUS_ZERO, ALU_ADD, 24'h0, 8'h00);
      chk("b_add_ac", b_ac, 0);
      chk("b_add_e", b_e, 1);
      chk("b_add_zero", b_acz, 1);
      step(PC_LD, BUS_MEM, ALU_PASS, 24'h00FFFF, 8'h00);
      chk("b_pc_ffff", b_pc, 16'hFFFF);
      step(PC_INC, BUS_ZERO, ALU_PASS, 24'h0, 8'h00);
      chk("b_pc_wrap", b_pc, 0);
      step(E_CLR, BUS_ZERO, ALU_PASS, 24'h0, 8'h00);
      step(DR_LD, BUS_MEM, ALU_PASS, 24'h800001, 8'h00);
      step(AC_LD, BUS_ZERO, ALU_LDDR, 24'h0, 8'h00);
      step(AC_LD | E_LD, BUS_ZERO, ALU_CIL, 24'h0, 8'h00);
      chk("b_cil_ac", b_ac, 24'h000002);
      chk("b_cil_e", b_e, 1);
      step(AC_LD | E_LD, BUS_ZERO, ALU_CIR, 24'h0, 8'h00);
      chk("b_cir_ac", b_ac, 24'h800001);
      chk("b_cir_e", b_e, 0);
      chk("b_ac_neg", b_acn, 1);
      step(IN_VLD, BUS_ZERO, ALU_PASS, 24'h0, 8'h5A);
      chk("b_fgi", b_fgi, 1);
      chk("b_in_ready", ifb.in_ready, 0);
      step(DR_LD, BUS_MEM, ALU_PASS, 24'h123400, 8'h00);
      chk("b_dr_zero_nz", b_drz, 0);
      step(AC_LD, BUS_ZERO, ALU_LDDR, 24'h0, 8'h00);
      step(AC_LD, BUS_ZERO, ALU_INPR, 24'h0, 8'h00);
      chk("b_inpr_merge", b_ac, 24'h12345A);
      step(OUTR_LD, BUS_AC, ALU_PASS, 24'h0, 8'h00);
      chk("b_outr", ifb.outr, 8'h5A);
      chk("b_out_valid", ifb.out_valid, 1);
      chk("b_fgo", b_fgo, 0);
      step(AR_LD, BUS_MEM, ALU_PASS, 24'hABCDEF, 8'h00);
      chk("b_ar", b_ar, 16'hCDEF);
      chk("b_mem_addr", ifb.mem_addr, 16'hCDEF);
      step(IR_LD | TR_LD, BUS_AR, ALU_PASS, 24'h0, 8'h00);
      chk("b_ir_zext", b_ir, 24'h00CDEF);
      chk("b_tr_zext", b_tr, 24'h00CDEF);
      bsel = BUS_AR; #1;
      chk("b_bus_ar", ifb.bus, 24'h00CDEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
